// File: rtl/aes128_cbc_ctrl.sv
// aes128_cbc_ctrl
// Initiator-side sequencer for one aes128_core instance. Takes 128-bit blocks
// from a valid/ready input stream, starts the core, waits for done, and
// returns the result on a valid/ready output stream. Only one block is in
// flight at a time.
// Optional feature macro: AES_CBC_EN. When it is defined, CBC chaining is
// applied. When it is undefined, the block runs plain ECB, and the IV is
// ignored.
module aes128_cbc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load_i,
    input  logic [127:0]     cfg_key_i,
    input  logic [127:0]     cfg_iv_i,
    input  logic             cfg_dec_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [127:0]     in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [127:0]     out_data_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] blk_cnt_o,
    output logic             core_start_enc_o,
    output logic             core_start_dec_o,
    output logic [127:0]     core_key_o,
    output logic [127:0]     core_text_o,
    input  logic [127:0]     core_text_i,
    input  logic             core_ready_i,
    input  logic             core_done_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       text_q, text_d;
    logic [127:0]       out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               issue_go;

`ifdef AES_CBC_EN
    logic [127:0]       chain_q, chain_d;
    logic [127:0]       save_q, save_d;
`else
    logic               unused_iv;
    assign unused_iv = ^cfg_iv_i;
`endif

    assign in_ready_o       = rst_n & (state_q == ST_IDLE) & ~cfg_load_i;
    assign accept           = in_valid_i & in_ready_o;
    assign issue_go         = rst_n & (state_q == ST_ISSUE) & core_ready_i;
    assign core_start_enc_o = issue_go & ~mode_q;
    assign core_start_dec_o = issue_go & mode_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign out_valid_o      = out_valid_q;
    assign out_data_o       = out_data_q;
    assign blk_cnt_o        = cnt_q;
    assign core_key_o       = key_q;
    assign core_text_o      = text_q;

    // Next-state logic: sequence the block through issue, wait and output handshakes.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        key_d       = key_q;
        text_d      = text_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
`ifdef AES_CBC_EN
        chain_d     = chain_q;
        save_d      = save_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cfg_load_i) begin
                    key_d  = cfg_key_i;
                    mode_d = cfg_dec_i;
                    cnt_d  = '0;
`ifdef AES_CBC_EN
                    chain_d = cfg_iv_i;
`endif
                end else if (accept) begin
`ifdef AES_CBC_EN
                    if (mode_q) begin
                        text_d = in_data_i;
                        save_d = in_data_i;
                    end else begin
                        text_d = in_data_i ^ chain_q;
                    end
`else
                    text_d = in_data_i;
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done_i) begin
`ifdef AES_CBC_EN
                    if (mode_q) begin
                        out_data_d = core_text_i ^ chain_q;
                        chain_d    = save_q;
                    end else begin
                        out_data_d = core_text_i;
                        chain_d    = core_text_i;
                    end
`else
                    out_data_d = core_text_i;
`endif
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            key_q       <= '0;
            text_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef AES_CBC_EN
            chain_q     <= '0;
            save_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            key_q       <= key_d;
            text_q      <= text_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
`ifdef AES_CBC_EN
            chain_q     <= chain_d;
            save_q      <= save_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes128_cbc_ctrl.sv
// tb_aes128_cbc_ctrl
// Scoreboard bench for aes128_cbc_ctrl. A behavioural stand-in core sits
// behind the DUT and uses an invertible keyed mock cipher. The reference model
// applies ECB or CBC chaining to whole blocks, following AES_CBC_EN.
module tb_aes128_cbc_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_load_i;
    logic [127:0]  cfg_key_i;
    logic [127:0]  cfg_iv_i;
    logic          cfg_dec_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [127:0]  in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [127:0]  out_data_o;
    logic          busy_o;
    logic [CW-1:0] blk_cnt_o;
    logic          core_start_enc_o;
    logic          core_start_dec_o;
    logic [127:0]  core_key_o;
    logic [127:0]  core_text_o;
    logic [127:0]  core_text_i;
    logic          core_ready_i;
    logic          core_done_i;

    int total = 0;
    int bad = 0;

    logic [127:0] sbQ[$];
    logic [127:0] mKey;
    logic [127:0] mChain;
    logic         mDec;
    int           expCnt;
    int           startCount = 0;
    int           acceptCount = 0;

    logic         coreBusy;
    logic         coreDoneLevel;
    int           coreLat;
    int           latMin;
    int           latMax;
    logic [127:0] coreRes;
    logic         coreReadyEn;
    bit           outRandom = 0;
    bit           coreRandom = 0;

    aes128_cbc_ctrl #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_load_i       (cfg_load_i),
        .cfg_key_i        (cfg_key_i),
        .cfg_iv_i         (cfg_iv_i),
        .cfg_dec_i        (cfg_dec_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_data_i        (in_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .busy_o           (busy_o),
        .blk_cnt_o        (blk_cnt_o),
        .core_start_enc_o (core_start_enc_o),
        .core_start_dec_o (core_start_dec_o),
        .core_key_o       (core_key_o),
        .core_text_o      (core_text_o),
        .core_text_i      (core_text_i),
        .core_ready_i     (core_ready_i),
        .core_done_i      (core_done_i)
    );

    always #5 clk = ~clk;

    // Keyed, invertible mock block cipher used by both the stand-in core and the model.
    function automatic logic [127:0] swapK(input logic [127:0] k);
        return {k[63:0], k[127:64]};
    endfunction

    function automatic logic [127:0] mockEnc(input logic [127:0] x, input logic [127:0] k);
        logic [127:0] t;
        t = x ^ k;
        return {t[114:0], t[127:115]} ^ swapK(k);
    endfunction

    function automatic logic [127:0] mockDec(input logic [127:0] y, input logic [127:0] k);
        logic [127:0] u;
        u = y ^ swapK(k);
        return {u[12:0], u[127:13]} ^ k;
    endfunction

    assign core_ready_i = coreReadyEn & ~coreBusy;

    // Stand-in core: latches the operation on a start, then raises done after a random latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            coreBusy    <= 1'b0;
            core_done_i <= 1'b0;
            coreLat     <= 0;
            core_text_i <= '0;
        end else if (core_start_enc_o || core_start_dec_o) begin
            coreBusy    <= 1'b1;
            core_done_i <= 1'b0;
            coreLat     <= $urandom_range(latMax, latMin);
            coreRes     <= core_start_dec_o ? mockDec(core_text_o, core_key_o)
                                            : mockEnc(core_text_o, core_key_o);
        end else if (coreBusy) begin
            if (coreLat == 0) begin
                coreBusy    <= 1'b0;
                core_done_i <= 1'b1;
                core_text_i <= coreRes;
            end else begin
                coreLat <= coreLat - 1;
            end
        end else if (!coreDoneLevel) begin
            core_done_i <= 1'b0;
        end
    end

    // Random sink backpressure and core-ready stalls, when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (outRandom) out_ready_i = ($urandom_range(3, 0) != 0);
            if (coreRandom) begin
                coreReadyEn   = ($urandom_range(3, 0) != 0);
                coreDoneLevel = $urandom_range(1, 0);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Reference model: whole-block ECB or CBC, in the order the blocks were accepted.
    task automatic pushExpected(input logic [127:0] d, output logic [127:0] r);
        if (!mDec) begin
`ifdef AES_CBC_EN
            r = mockEnc(d ^ mChain, mKey);
            mChain = r;
`else
            r = mockEnc(d, mKey);
`endif
        end else begin
`ifdef AES_CBC_EN
            r = mockDec(d, mKey) ^ mChain;
            mChain = d;
`else
            r = mockDec(d, mKey);
`endif
        end
        sbQ.push_back(r);
        acceptCount++;
    endtask

    // Monitor: counts core starts and pops the scoreboard on every output transfer.
    initial begin
        logic [127:0] prevData;
        bit prevHold;
        prevHold = 0;
        prevData = '0;
        forever begin
            @(negedge clk);
            #2;
            if (core_start_enc_o || core_start_dec_o) begin
                startCount++;
                checkOutput("start_core_ready", {127'd0, core_ready_i}, 128'd1);
                checkOutput("start_mode_dec", {127'd0, core_start_dec_o}, {127'd0, mDec});
            end
            if (out_valid_o) begin
                if (prevHold) checkOutput("out_stable", out_data_o, prevData);
                if (out_ready_i) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("out_unexpected", {127'd0, out_valid_o}, 128'd0);
                    end else begin
                        checkOutput("out_data", out_data_o, sbQ.pop_front());
                    end
                    checkOutput("blk_cnt_at_xfer", {124'd0, blk_cnt_o}, 128'(expCnt));
                    expCnt = (expCnt + 1) % (1 << CW);
                    prevHold = 0;
                end else begin
                    prevHold = 1;
                    prevData = out_data_o;
                end
            end else begin
                prevHold = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [127:0] d, output logic [127:0] r);
        bit taken;
        taken = 0;
        r = '0;
        @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = d;
        for (int n = 0; n < 500 && !taken; n++) begin
            #1;
            if (in_ready_o) begin
                pushExpected(d, r);
                taken = 1;
            end
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        if (!taken) failNow("accept_timeout");
    endtask

    task automatic loadCfg(input logic [127:0] k, input logic [127:0] iv, input logic dec);
        @(negedge clk);
        cfg_load_i = 1'b1;
        cfg_key_i  = k;
        cfg_iv_i   = iv;
        cfg_dec_i  = dec;
        mKey   = k;
        mChain = iv;
        mDec   = dec;
        expCnt = 0;
        @(negedge clk);
        cfg_load_i = 1'b0;
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 0;
        for (int n = 0; n < 2000 && !idle; n++) begin
            @(negedge clk);
            #3;
            if (sbQ.size() == 0 && !busy_o && !out_valid_o) idle = 1;
        end
        if (!idle) failNow("drain_timeout");
    endtask

    task automatic waitOutValid();
        bit seen;
        seen = 0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (out_valid_o) seen = 1;
        end
        if (!seen) failNow("out_valid_timeout");
    endtask

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2  = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        logic [127:0] r;
        logic [127:0] ct0;
        logic [127:0] ct1;
        logic [127:0] holdData;
        int s0;

        rst_n = 1'b0; cfg_load_i = 1'b0; cfg_key_i = '0; cfg_iv_i = '0; cfg_dec_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 128'h1234; out_ready_i = 1'b1;
        coreReadyEn = 1'b1; coreDoneLevel = 1'b0; latMin = 0; latMax = 2;
        mKey = '0; mChain = '0; mDec = 1'b0; expCnt = 0;

        // Reset values, with in_valid_i high throughout reset
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_in_ready", {127'd0, in_ready_o}, 128'd0);
        checkOutput("rst_out_valid", {127'd0, out_valid_o}, 128'd0);
        checkOutput("rst_out_data", out_data_o, 128'd0);
        checkOutput("rst_busy", {127'd0, busy_o}, 128'd0);
        checkOutput("rst_blk_cnt", {124'd0, blk_cnt_o}, 128'd0);
        checkOutput("rst_core_key", core_key_o, 128'd0);
        checkOutput("rst_core_text", core_text_o, 128'd0);
        checkOutput("rst_starts", {126'd0, core_start_enc_o, core_start_dec_o}, 128'd0);
        in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single encrypt with IV zero, exactly one start pulse
        loadCfg(KEY1, 128'd0, 1'b0);
        s0 = startCount;
        applyStimulus(128'h3243f6a8885a308d313198a2e0370734, r);
        waitIdle();
        checkOutput("t1_blk_cnt", {124'd0, blk_cnt_o}, 128'd1);
        checkOutput("t1_starts", 128'(startCount - s0), 128'd1);
        checkOutput("t1_core_key", core_key_o, KEY1);

        // Two chained encrypts
        loadCfg(KEY1, IV2, 1'b0);
        applyStimulus(128'h6bc1bee22e409f96e93d7e117393172a, ct0);
        applyStimulus(128'hae2d8a571e03ac9c9eb76fac45af8e51, ct1);
        waitIdle();
        checkOutput("t2_blk_cnt", {124'd0, blk_cnt_o}, 128'd2);

        // Decrypt the two ciphertexts back, with done held as a level
        coreDoneLevel = 1'b1;
        loadCfg(KEY1, IV2, 1'b1);
        applyStimulus(ct0, r);
        checkOutput("t3_plain0", r, 128'h6bc1bee22e409f96e93d7e117393172a);
        applyStimulus(ct1, r);
        checkOutput("t3_plain1", r, 128'hae2d8a571e03ac9c9eb76fac45af8e51);
        waitIdle();
        checkOutput("t3_blk_cnt", {124'd0, blk_cnt_o}, 128'd2);
        coreDoneLevel = 1'b0;

        // Output backpressure for ten cycles, then a back-to-back accept
        loadCfg(KEY1, IV2, 1'b0);
        @(negedge clk);
        out_ready_i = 1'b0;
        applyStimulus(128'hdeadbeef_00000000_cafef00d_11111111, r);
        waitOutValid();
        holdData = out_data_o;
        s0 = startCount;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_valid", {127'd0, out_valid_o}, 128'd1);
            checkOutput("bp_data", out_data_o, r);
            checkOutput("bp_in_ready", {127'd0, in_ready_o}, 128'd0);
        end
        checkOutput("bp_no_start", 128'(startCount - s0), 128'd0);
        out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        in_data_i = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        @(negedge clk);
        #1;
        checkOutput("bp_next_ready", {127'd0, in_ready_o}, 128'd1);
        if (in_ready_o) pushExpected(in_data_i, r);
        @(negedge clk);
        in_valid_i = 1'b0;
        waitIdle();
        checkOutput("bp_blk_cnt", {124'd0, blk_cnt_o}, 128'd2);

        // cfg_load_i colliding with in_valid_i in IDLE: load wins, nothing accepted
        @(negedge clk);
        cfg_load_i = 1'b1; cfg_key_i = 128'h55; cfg_iv_i = 128'h77; cfg_dec_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 128'h99;
        mKey = 128'h55; mChain = 128'h77; mDec = 1'b0; expCnt = 0;
        #1;
        checkOutput("col_in_ready", {127'd0, in_ready_o}, 128'd0);
        @(negedge clk);
        cfg_load_i = 1'b0; in_valid_i = 1'b0;
        #1;
        checkOutput("col_blk_cnt", {124'd0, blk_cnt_o}, 128'd0);
        checkOutput("col_busy", {127'd0, busy_o}, 128'd0);
        checkOutput("col_key", core_key_o, 128'h55);

        // cfg_load_i during WAIT is ignored
        latMin = 6; latMax = 6;
        applyStimulus(128'hab, r);
        repeat (2) @(negedge clk);
        cfg_load_i = 1'b1; cfg_key_i = 128'hffff; cfg_iv_i = 128'h1; cfg_dec_i = 1'b1;
        @(negedge clk);
        cfg_load_i = 1'b0;
        #1;
        checkOutput("wait_load_busy", {127'd0, busy_o}, 128'd1);
        waitIdle();
        applyStimulus(128'hcd, r);
        waitIdle();
        checkOutput("wait_load_key", core_key_o, 128'h55);
        checkOutput("wait_load_cnt", {124'd0, blk_cnt_o}, 128'd2);

        // core_ready_i low in ISSUE defers the start
        latMin = 0; latMax = 2;
        coreReadyEn = 1'b0;
        s0 = startCount;
        applyStimulus(128'hef, r);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("defer_no_start", 128'(startCount - s0), 128'd0);
        checkOutput("defer_busy", {127'd0, busy_o}, 128'd1);
        coreReadyEn = 1'b1;
        waitIdle();
        checkOutput("defer_one_start", 128'(startCount - s0), 128'd1);

        // Reset while waiting on the core abandons the block
        latMin = 6; latMax = 6;
        applyStimulus(128'h4242, r);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        sbQ.delete();
        mKey = '0; mChain = '0; mDec = 1'b0; expCnt = 0;
        checkOutput("wrst_out_valid", {127'd0, out_valid_o}, 128'd0);
        checkOutput("wrst_out_data", out_data_o, 128'd0);
        checkOutput("wrst_busy", {127'd0, busy_o}, 128'd0);
        checkOutput("wrst_blk_cnt", {124'd0, blk_cnt_o}, 128'd0);
        checkOutput("wrst_core_key", core_key_o, 128'd0);
        checkOutput("wrst_core_text", core_text_o, 128'd0);
        checkOutput("wrst_in_ready", {127'd0, in_ready_o}, 128'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkOutput("wrst_no_out", {127'd0, out_valid_o}, 128'd0);
        end
        latMin = 0; latMax = 2;
        loadCfg(KEY1, 128'd0, 1'b0);
        applyStimulus(128'h3243f6a8885a308d313198a2e0370734, r);
        waitIdle();
        checkOutput("rerun_blk_cnt", {124'd0, blk_cnt_o}, 128'd1);

        // Random traffic with stalls, backpressure and reloads; counter wraps
        latMin = 0; latMax = 3;
        outRandom = 1; coreRandom = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                waitIdle();
                loadCfg({$urandom, $urandom, $urandom, $urandom},
                        {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1, 0)));
            end
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, r);
        end
        @(negedge clk);
        outRandom = 0; coreRandom = 0;
        @(negedge clk);
        out_ready_i = 1'b1; coreReadyEn = 1'b1; coreDoneLevel = 1'b0;
        waitIdle();
        checkOutput("starts_vs_blocks", 128'(startCount), 128'(acceptCount));
        checkOutput("final_blk_cnt", {124'd0, blk_cnt_o}, 128'(expCnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
